// File: rtl/qam_symbol_unpacker.sv
// Byte-to-nibble unpacker feeding the 16-QAM mapper: a small byte FIFO drained
// by a nibble FSM that releases one 4-bit symbol per SPS-clock slot.
module qam_symbol_unpacker #(
  parameter int SPS        = 4,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_byte,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [3:0]                    sym_out,
  output logic                          sym_valid,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    fsm_state
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int PHW = $clog2(SPS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  // Handshake: a byte transfers on a clock edge where in_valid && in_ready;
  // in_ready depends only on the stored count, never on in_valid.

  state_t           state, state_next;
  logic [PHW-1:0]   phase;
  logic             slot;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             fifo_empty, push, pop;
  logic [7:0]       hold;
  logic             emit, emit_first, starve;
  logic [3:0]       sym_next;

  // Symbol-slot timebase
  assign slot = (phase == PHW'(SPS - 1));

  always_ff @(posedge clk) begin
    if (!rst)      phase <= '0;
    else if (slot) phase <= '0;
    else           phase <= phase + 1'b1;
  end

  assign fifo_empty = (count == '0);
  assign in_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_level = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_byte;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = FIRST;
      FIRST:   if (slot)        state_next = SECOND;
      SECOND:  if (slot)        state_next = fifo_empty ? IDLE : FIRST;
      default:                  state_next = IDLE;
    endcase
  end

  // The IDLE slot still counts as starved even when a pop lands on it.
  always_comb begin
    pop        = 1'b0;
    emit       = 1'b0;
    emit_first = 1'b0;
    starve     = 1'b0;
    case (state)
      IDLE: begin
        pop    = !fifo_empty;
        starve = slot;
      end
      FIRST: begin
        emit       = slot;
        emit_first = 1'b1;
      end
      SECOND: begin
        emit = slot;
        pop  = slot && !fifo_empty;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (emit_first == MSB_FIRST) sym_next = hold[7:4];
    else                         sym_next = hold[3:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold      <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      sym_valid <= emit;
      underrun  <= starve;
      if (emit) sym_out <= sym_next;
      if (pop)  hold    <= mem[rd_ptr];
    end
  end

  assign fsm_state = state;

endmodule

// File: doc/qam_symbol_unpacker.md
# qam_symbol_unpacker

Upstream feeder for the 16-QAM constellation mapper in the transmit chain. It accepts a valid/ready byte stream, buffers bytes in a small FIFO and splits each byte into two 4-bit symbols. Symbols are released at a fixed symbol rate of one per SPS clocks, so the mapper and the RRC interpolator downstream see a regular symbol grid. Starvation is flagged, never hidden.

## Interface
Parameters:
- SPS, 4, clock cycles per symbol slot; integer ≥ 2.
- FIFO_DEPTH, 4, byte FIFO entries; power of 2, ≥ 2.
- MSB_FIRST, 1, 1 = emit byte[7:4] then byte[3:0]; 0 = reverse order.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_byte  in  8  input byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  FIFO can accept a byte.
- sym_out  out  4  current symbol, fed to the mapper input; held between slots.
- sym_valid  out  1  one-cycle pulse: sym_out was updated at this edge.
- underrun  out  1  one-cycle pulse: a slot elapsed with no symbol available.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently stored.

## Operation
- FIFO: circular buffer with separate read and write pointers and an occupancy count.
  - in_ready = (fifo_level != FIFO_DEPTH), combinational from the count.
  - Push on an edge when in_valid && in_ready.
  - When full, there is no push, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle are allowed when not full; the count is unchanged.
- Phase counter: 0..SPS-1, free-running, increments every edge while rst=1, wraps to 0.
  - slot = (phase == SPS-1), combinational.
- Nibble FSM, with an 8-bit holding register:
  - IDLE: register empty. At any edge with FIFO non-empty, pop the head into the register and go to FIRST. A slot in IDLE raises an underrun, whether or not a pop occurs at that edge.
  - FIRST: at a slot edge, load sym_out with the first nibble, pulse sym_valid, go to SECOND.
  - SECOND: at a slot edge, load sym_out with the second nibble and pulse sym_valid.
    - If the FIFO is non-empty, pop the next byte into the register at the same edge and go to FIRST.
    - Otherwise go to IDLE.
  - No state change occurs on non-slot edges, except the IDLE pop.
- sym_out holds its last value during an underrun. sym_valid stays 0 and underrun pulses 1.
- Reset (rst=0 at an edge), at any time, including mid-byte:
  - phase=0, state IDLE, FIFO emptied, pointers=0, holding register=0.
  - sym_out=4'b0000, sym_valid=0, underrun=0, fifo_level=0.
  - in_ready=1 after the reset edge.
  - A partially emitted byte is discarded.

## Timing
- Edge k=1 is the first edge with rst=1; slot edges are at k where (k-1) mod SPS = SPS-1. For SPS=4, these are k = 4, 8, 12, …
- Byte pushed into an empty block in IDLE at edge N:
  - popped at edge N+1;
  - first nibble at the first slot edge ≥ N+2;
  - second nibble SPS edges later.
- Steady-state throughput is one byte per 2·SPS clocks. Sustained input at a higher rate fills the FIFO and deasserts in_ready.
- sym_valid and underrun are registered and are never both 1. Across all slots, exactly one of them pulses per slot edge.
- fifo_level updates on the edge after the push/pop.

## Test plan
- Reset, then SPS=4, MSB_FIRST=1: push 0xA5 at edge 1 → in_ready=1 throughout. sym_out=0xA with sym_valid at edge 4, sym_out=0x5 at edge 8, underrun at edges 12 and 16. sym_out holds 0x5.
- Back-to-back push of 0x12, 0x34, 0x56, 0x78, 0x9A with in_valid held high → fifo_level reaches 4 and in_ready drops. The 5th byte is accepted only after a pop. Symbols 1,2,3,4,5,6,7,8,9,A appear on consecutive slots with no underrun.
- MSB_FIRST=0, push 0xC3 → symbols 0x3 then 0xC.
- Assert rst=0 between the first and second nibble of 0xF0 with 2 bytes queued → next edge: sym_out=0, fifo_level=0, in_ready=1. After release there are only underruns until a new push; 0x0 from 0xF0 never appears.
- Push with in_valid=1 when full and a pop at the same edge → the byte is not accepted. fifo_level goes 4→3, in_ready rises the next cycle, and the byte is accepted then.
- Random valid gaps over 1000 bytes → the emitted symbol sequence equals the nibble-split input. Counts of sym_valid + underrun equal the number of slots, and sym_valid and underrun never coincide.
